// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Staged reset controller for the camera pipeline. Stage 0 is sensor/I2C
//   config, stage 1 is the SDRAM controller, stage 2 is the capture/VGA
//   datapath. Bring-up releases the stages in the order 0,1,2. Each release
//   after the first waits for the ready of the stage released before it.
//   A soft-reset request in READY shuts the stages down in the order 2,1,0.
//   The sequencer then holds all resets and runs bring-up again.
//
// Ports
//   iCLK            system clock
//   iRST            asynchronous active-low reset
//   iREQ            soft-reset request (level, acted on only in READY)
//   iRDY_0..iRDY_2  per-stage ready / init-done levels
//   oRST_0..oRST_2  per-stage resets, active-low (0 = held in reset)
//   oBUSY           1 in every state except READY
//   oERR            sticky ready-timeout flag
//
// Build option
//   RSTSEQ_TIMEOUT_EN: if a WAITn state sees no ready within TIMEOUT_CYC
//   cycles, the sequencer sets oERR and retries with a full shutdown.
//   When the macro is undefined, WAITn waits indefinitely and oERR is 0.
//
// All outputs are registered. Each one changes on the edge that enters
// the state responsible for the change.
module reset_sequencer #(
  parameter logic [31:0] ASSERT_GAP  = 32'd16,
  parameter logic [31:0] HOLD_CYC    = 32'h1FFFFF,
  parameter logic [31:0] RELEASE_GAP = 32'h0FFFFF
`ifdef RSTSEQ_TIMEOUT_EN
  ,
  parameter logic [31:0] TIMEOUT_CYC = 32'h3FFFFFF
`endif
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iREQ,
  input  logic iRDY_0,
  input  logic iRDY_1,
  input  logic iRDY_2,
  output logic oRST_0,
  output logic oRST_1,
  output logic oRST_2,
  output logic oBUSY,
  output logic oERR
);

  typedef enum logic [3:0] {
    HOLD, REL0, WAIT0, REL1, WAIT1, REL2, WAIT2, READY, SHUT2, SHUT1, SHUT0
  } stateT;

  stateT       state, stateNxt;
  logic [31:0] cnt;
  logic        rst0Nxt, rst1Nxt, rst2Nxt;
  logic        timeout;

`ifdef RSTSEQ_TIMEOUT_EN
  assign timeout = (cnt == TIMEOUT_CYC - 32'd1);
`else
  assign timeout = 1'b0;
`endif

  // Output next-values default to "hold". A timeout retry enters SHUT2
  // from the current reset values, so a stage that is still in reset
  // stays in reset through its shutdown step.
  always_comb begin
    stateNxt = state;
    rst0Nxt  = oRST_0;
    rst1Nxt  = oRST_1;
    rst2Nxt  = oRST_2;
    case (state)
      HOLD:  if (cnt == HOLD_CYC - 32'd1) stateNxt = REL0;
      REL0:  if (cnt == RELEASE_GAP - 32'd1) begin
               stateNxt = WAIT0;
               rst0Nxt  = 1'b1;
             end
      WAIT0: if (iRDY_0) stateNxt = REL1;
             else if (timeout) begin
               stateNxt = SHUT2;
               rst2Nxt  = 1'b0;
             end
      REL1:  if (cnt == RELEASE_GAP - 32'd1) begin
               stateNxt = WAIT1;
               rst1Nxt  = 1'b1;
             end
      WAIT1: if (iRDY_1) stateNxt = REL2;
             else if (timeout) begin
               stateNxt = SHUT2;
               rst2Nxt  = 1'b0;
             end
      REL2:  if (cnt == RELEASE_GAP - 32'd1) begin
               stateNxt = WAIT2;
               rst2Nxt  = 1'b1;
             end
      WAIT2: if (iRDY_2) stateNxt = READY;
             else if (timeout) begin
               stateNxt = SHUT2;
               rst2Nxt  = 1'b0;
             end
      READY: if (iREQ) begin
               stateNxt = SHUT2;
               rst2Nxt  = 1'b0;
             end
      SHUT2: if (cnt == ASSERT_GAP - 32'd1) begin
               stateNxt = SHUT1;
               rst1Nxt  = 1'b0;
             end
      SHUT1: if (cnt == ASSERT_GAP - 32'd1) begin
               stateNxt = SHUT0;
               rst0Nxt  = 1'b0;
             end
      SHUT0: if (cnt == ASSERT_GAP - 32'd1) stateNxt = HOLD;
      default: begin
        stateNxt = HOLD;
        rst0Nxt  = 1'b0;
        rst1Nxt  = 1'b0;
        rst2Nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state  <= HOLD;
      cnt    <= '0;
      oRST_0 <= 1'b0;
      oRST_1 <= 1'b0;
      oRST_2 <= 1'b0;
      oBUSY  <= 1'b1;
    end else begin
      state  <= stateNxt;
      cnt    <= (stateNxt != state) ? '0 : cnt + 32'd1;
      oRST_0 <= rst0Nxt;
      oRST_1 <= rst1Nxt;
      oRST_2 <= rst2Nxt;
      oBUSY  <= (stateNxt != READY);
    end
  end

`ifdef RSTSEQ_TIMEOUT_EN
  // SHUT2 is entered from a WAIT state only through a timeout.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)
      oERR <= 1'b0;
    else if ((state == WAIT0 || state == WAIT1 || state == WAIT2) &&
             stateNxt == SHUT2)
      oERR <= 1'b1;
  end
`else
  assign oERR = 1'b0;
`endif

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Drives the staged reset controls for the camera pipeline (stage 0 = sensor/I2C config, stage 1 = SDRAM controller, stage 2 = capture/VGA datapath), after power-up and on a soft-reset request.
- Shutdown asserts resets in reverse order (2, 1, 0); bring-up releases them in forward order (0, 1, 2).
- Each release is gated by a ready handshake from the stage just released.
- Sits at top level between KEY/board reset and the subsystem reset inputs.

Parameters:
- ASSERT_GAP, 16, cycles between successive reset assertions during shutdown (>=1).
- HOLD_CYC, 32'h1FFFFF, cycles all three resets stay asserted before bring-up (>=1).
- RELEASE_GAP, 32'h0FFFFF, cycles from entering a release state (after the previous stage's ready) to releasing the next stage (>=1).
- TIMEOUT_CYC, 32'h3FFFFFF, max cycles to wait for iRDY_n after release (used only with the optional feature).

Ports:
- iCLK  input  1  system clock.
- iRST  input  1  asynchronous active-low reset.
- iREQ  input  1  soft-reset request, level-sampled; acted on only in READY.
- iRDY_0  input  1  stage 0 ready/init-done, level.
- iRDY_1  input  1  stage 1 ready/init-done, level.
- iRDY_2  input  1  stage 2 ready/init-done, level.
- oRST_0  output  1  stage 0 reset, active-low (0 = held in reset).
- oRST_1  output  1  stage 1 reset, active-low.
- oRST_2  output  1  stage 2 reset, active-low.
- oBUSY  output  1  1 in every state except READY.
- oERR  output  1  sticky timeout flag (optional feature only; constant 0 otherwise).

Behaviour:
- Clock and reset: one clock iCLK; reset iRST is asynchronous, active-low.
- On iRST=0: state=HOLD, counter=0, oRST_0/1/2=0, oBUSY=1, oERR=0.
- Counter: one 32-bit counter, cleared on every state transition.
- Output encoding: all outputs are registered. Each oRST_n changes on the same edge the FSM enters the state that changes it.
- HOLD: all oRST=0. When counter==HOLD_CYC-1, go to REL0.
- REL0: count RELEASE_GAP cycles, then set oRST_0=1 and go to WAIT0.
- WAIT0: stay until iRDY_0=1, then go to REL1.
- REL1 / WAIT1 and REL2 / WAIT2: same pattern for stages 1 and 2.
- WAIT2 exit: on iRDY_2=1, go to READY.
- Full bring-up latency: HOLD_CYC + 3*RELEASE_GAP + 3 cycles minimum (ready levels already high), plus the time spent waiting for each ready.
- READY: oBUSY=0, all oRST=1. On iREQ=1, go to SHUT2 and set oRST_2=0 on that edge.
- SHUT2: after ASSERT_GAP cycles, go to SHUT1 and set oRST_1=0.
- SHUT1: after ASSERT_GAP cycles, go to SHUT0 and set oRST_0=0.
- SHUT0: after ASSERT_GAP cycles, go to HOLD (counter restarts).
- iREQ outside READY: ignored; no queuing.
- iREQ held high: a new shutdown starts one cycle after READY is reached.
- iRDY_n low in any state other than WAIT_n: ignored.
- Ready drop after release: if a ready falls after its stage is released, no action is taken (no auto-reset).
- Async iRST in any state, including mid-shutdown or mid-release: immediately returns to the reset values; the full sequence restarts from HOLD.
- Release order is strict: oRST_1 never rises while oRST_0=0; oRST_2 never rises while oRST_1=0.
- Assertion order is strict: oRST_0 never falls while oRST_1=1; oRST_1 never falls while oRST_2=1.

Optional Feature:
- Macro RSTSEQ_TIMEOUT_EN.
- Defined: in WAITn, if counter reaches TIMEOUT_CYC-1 with iRDY_n still 0:
  - set oERR=1 (sticky, cleared only by iRST);
  - go to SHUT2 for a full retry (shutdown in the normal order from the current oRST values).
  - A stage whose oRST is already 0 is simply held at 0 through its SHUT step.
  - Retries are unlimited.
- Not defined: WAITn waits indefinitely; oERR is tied to 0; no timeout compare logic is synthesized.

Test Plan:
- Power-up: set HOLD_CYC=8, RELEASE_GAP=4, iRDY_0/1/2 tied 1, release iRST -> oRST_0 rises at cycle 13, oRST_1 at 18, oRST_2 at 23; oBUSY falls at cycle 24.
- Gated release: hold iRDY_1=0 for 100 cycles after oRST_1 rises -> oRST_2 stays 0; rises RELEASE_GAP+1 cycles after iRDY_1 goes high.
- Soft reset: in READY, pulse iREQ for 1 cycle with ASSERT_GAP=4 -> oRST_2 falls next edge, oRST_1 4 cycles later, oRST_0 4 cycles after that; then the HOLD plus release sequence repeats. An iREQ pulse during the sequence has no effect.
- Mid-operation reset: assert iRST during WAIT1 -> all oRST=0 and oBUSY=1 immediately (async); sequence restarts from HOLD with counter=0.
- Ordering checker: random iRDY toggling and iREQ over 10k cycles -> assertions on release and assertion order never fire.
- Timeout (RSTSEQ_TIMEOUT_EN, TIMEOUT_CYC=20): keep iRDY_0=0 -> after 20 cycles in WAIT0, oERR=1 and the FSM enters SHUT2. Raise iRDY_0 later -> bring-up completes with oERR still 1.
